main_mem_responder: RTL

MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

---
 rtl/main_mem_responder.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/main_mem_responder.sv
// -----------------------------------------------------------------------------
// main_mem_responder
//   Memory-side responder for a single outstanding cache line request.
//   A line fill returns BEATS data beats from the backing store after LATENCY
//   cycles; a line writeback takes BEATS data beats, waits LATENCY cycles and
//   returns a single acknowledge beat. A new request is taken only once the
//   current response has fully completed.
//
// Ports
//   i_clk          clock, all state on rising edge
//   i_rst          asynchronous active-high reset
//   i_req_valid    cache line request present
//   o_req_ready    responder can accept a request (IDLE only)
//   i_req_addr     line byte address
//   i_req_write    1 = line writeback, 0 = line fill
//   i_wdata_valid  writeback beat present
//   o_wdata_ready  responder accepts writeback beat
//   i_wdata        writeback beat data
//   o_resp_valid   response beat present
//   i_resp_ready   requester accepts response beat
//   o_resp_data    fill beat data; 0 on write acknowledge
//   o_resp_last    final beat of response
//   o_resp_is_wr   response is a writeback acknowledge
// -----------------------------------------------------------------------------
module main_mem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int BEATS       = 4,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic              i_req_write,
    input  logic              i_wdata_valid,
    output logic              o_wdata_ready,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_resp_valid,
    input  logic              i_resp_ready,
    output logic [DATA_W-1:0] o_resp_data,
    output logic              o_resp_last,
    output logic              o_resp_is_wr
);

    localparam int BYTE_SH = $clog2(DATA_W / 8);
    localparam int BW      = $clog2(BEATS);
    localparam int AW      = $clog2(DEPTH_WORDS);
    localparam int LW      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_DATA,
        S_WAIT,
        S_RD_BURST,
        S_WR_ACK
    } state_t;

    state_t            r_state;
    logic [AW-1:0]     r_base;
    logic [BW-1:0]     r_beat;
    logic [LW-1:0]     r_lat;
    logic              r_is_wr;
    logic              r_resp_valid;
    logic              r_resp_last;
    logic              r_resp_is_wr;
    logic [DATA_W-1:0] r_resp_data;

    // Backing store: deliberately not reset so contents survive i_rst.
    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

    logic [AW-1:0]     w_req_word;
    logic [AW-1:0]     w_req_base;
    logic [AW-1:0]     w_cur_idx;
    logic [AW-1:0]     w_next_idx;
    logic              w_last_beat;
    logic              w_wr_en;

    // Byte address -> word index, truncated to the store depth (modulo
    // DEPTH_WORDS), then line-aligned by clearing the beat-select bits.
    assign w_req_word  = AW'(i_req_addr >> BYTE_SH);
    assign w_req_base  = w_req_word & ~AW'(BEATS - 1);
    assign w_cur_idx   = r_base + AW'(r_beat);
    assign w_next_idx  = w_cur_idx + AW'(1);
    assign w_last_beat = (r_beat == BW'(BEATS - 1));
    assign w_wr_en     = (r_state == S_WR_DATA) && i_wdata_valid;

    // req_ready is held low while reset is asserted, high in IDLE otherwise.
    assign o_req_ready   = (r_state == S_IDLE) && !i_rst;
    assign o_wdata_ready = (r_state == S_WR_DATA);
    assign o_resp_valid  = r_resp_valid;
    assign o_resp_data   = r_resp_data;
    assign o_resp_last   = r_resp_last;
    assign o_resp_is_wr  = r_resp_is_wr;

    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[w_cur_idx] <= i_wdata;
        end
    end

    // Response data is registered: the first beat is fetched on leaving
    // WAIT and each following beat is fetched on the handshake of the
    // previous one, so outputs hold steady across stalls.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_base       <= '0;
            r_beat       <= '0;
            r_lat        <= '0;
            r_is_wr      <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_last  <= 1'b0;
            r_resp_is_wr <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_base  <= w_req_base;
                        r_is_wr <= i_req_write;
                        r_beat  <= '0;
                        r_lat   <= '0;
                        r_state <= i_req_write ? S_WR_DATA : S_WAIT;
                    end
                end
                S_WR_DATA: begin
                    if (i_wdata_valid) begin
                        if (w_last_beat) begin
                            r_beat  <= '0;
                            r_lat   <= '0;
                            r_state <= S_WAIT;
                        end else begin
                            r_beat <= r_beat + BW'(1);
                        end
                    end
                end
                S_WAIT: begin
                    if (r_lat == LW'(LATENCY - 1)) begin
                        r_lat        <= '0;
                        r_beat       <= '0;
                        r_resp_valid <= 1'b1;
                        if (r_is_wr) begin
                            r_state      <= S_WR_ACK;
                            r_resp_last  <= 1'b1;
                            r_resp_is_wr <= 1'b1;
                            r_resp_data  <= '0;
                        end else begin
                            r_state      <= S_RD_BURST;
                            r_resp_last  <= 1'b0;
                            r_resp_is_wr <= 1'b0;
                            r_resp_data  <= r_mem[r_base];
                        end
                    end else begin
                        r_lat <= r_lat + LW'(1);
                    end
                end
                S_RD_BURST: begin
                    if (i_resp_ready) begin
                        if (w_last_beat) begin
                            r_state      <= S_IDLE;
                            r_beat       <= '0;
                            r_resp_valid <= 1'b0;
                            r_resp_last  <= 1'b0;
                            r_resp_data  <= '0;
                        end else begin
                            r_beat      <= r_beat + BW'(1);
                            r_resp_data <= r_mem[w_next_idx];
                            r_resp_last <= (r_beat == BW'(BEATS - 2));
                        end
                    end
                end
                S_WR_ACK: begin
                    if (i_resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                        r_resp_last  <= 1'b0;
                        r_resp_is_wr <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
